// File: rtl/dsp_pkg.sv
// Shared DSP definitions: config register map and the round/shift/saturate helper.
package dsp_pkg;

    localparam int unsigned ADDR_RATIO  = 0;
    localparam int unsigned ADDR_SHIFT  = 1;
    localparam int unsigned ADDR_SATCNT = 2;

    // Round half up, arithmetic shift right by 'shift', then clip to a signed 'ow'-bit range.
    // The 64-bit working width leaves headroom for any accumulator up to 62 bits.
    function automatic logic signed [63:0] round_shift_sat(
        input  logic signed [63:0] sum,
        input  int unsigned        shift,
        input  int unsigned        ow,
        output logic               clipped
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r = sum;
        if (shift > 0) begin
            r = r + (64'sd1 <<< (shift - 1));
        end
        r       = r >>> shift;
        max_v   = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (ow - 1));
        clipped = 1'b0;
        if (r > max_v) begin
            r       = max_v;
            clipped = 1'b1;
        end else if (r < min_v) begin
            r       = min_v;
            clipped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/accum_decimator_if.sv
// Stream-in, stream-out and config-bus signals of the accumulate-and-dump decimator.
interface accum_decimator_if #(
    parameter int unsigned DW    = 24,
    parameter int unsigned CFGAW = 32,
    parameter int unsigned CFGDW = 32
) ();
    logic signed [DW-1:0]    s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic signed [DW-1:0]    m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    cyc_i;
    logic                    stb_i;
    logic                    we_i;
    logic                    ack_o;
    logic                    stall_o;
    logic [CFGAW-1:0]        addr_i;
    logic [CFGDW-1:0]        data_i;
    logic [CFGDW-1:0]        data_o;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  cyc_i, stb_i, we_i, addr_i, data_i,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid,
        output ack_o, stall_o, data_o
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output cyc_i, stb_i, we_i, addr_i, data_i,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid,
        input  ack_o, stall_o, data_o
    );
endinterface

// File: rtl/accum_decimator_wbregs.sv
// Generic Wishbone-style register file: N_CTL read/write words followed by N_STS read-only words.
module WbRegs #(
    parameter int unsigned              CFGAW       = 32,
    parameter int unsigned              CFGDW       = 32,
    parameter int unsigned              N_CTL       = 2,
    parameter int unsigned              N_STS       = 1,
    parameter int unsigned              STS_W       = 16,
    parameter bit                       SIGN_EXTEND = 1'b0,
    parameter logic [N_CTL*CFGDW-1:0]   CTL_RST     = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cyc_i,
    input  logic                              stb_i,
    input  logic                              we_i,
    input  logic [CFGAW-1:0]                  addr_i,
    input  logic [CFGDW-1:0]                  data_i,
    output logic                              ack_o,
    output logic                              stall_o,
    output logic [CFGDW-1:0]                  data_o,
    output logic [N_CTL-1:0][CFGDW-1:0]       ctl_o,
    input  logic [N_STS-1:0][STS_W-1:0]       sts_i
);
    logic [N_CTL-1:0][CFGDW-1:0] ctl_q, ctl_d;
    logic                        ack_q, ack_d;
    logic [CFGDW-1:0]            data_q, data_d;
    logic                        req;

    always_comb begin
        req    = cyc_i && stb_i;
        ctl_d  = ctl_q;
        ack_d  = req;
        data_d = '0;
        for (int unsigned i = 0; i < N_CTL; i++) begin
            if (req && addr_i == CFGAW'(i)) begin
                if (we_i) ctl_d[i] = data_i;
                else      data_d   = ctl_q[i];
            end
        end
        // Status words sit directly above the control words; bus writes to them are dropped.
        for (int unsigned j = 0; j < N_STS; j++) begin
            if (req && !we_i && addr_i == CFGAW'(N_CTL + j)) begin
                data_d = SIGN_EXTEND ? CFGDW'(signed'(sts_i[j])) : CFGDW'(sts_i[j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q  <= CTL_RST;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ctl_q  <= ctl_d;
            ack_q  <= ack_d;
            data_q <= data_d;
        end
    end

    assign ctl_o   = ctl_q;
    assign ack_o   = ack_q;
    assign stall_o = 1'b0;
    assign data_o  = data_q;
endmodule

// File: rtl/accum_decimator.sv
// Integrate-and-dump decimator: sums R input samples, emits one rounded, shifted, saturated output.
module accum_decimator
    import dsp_pkg::*;
#(
    parameter int unsigned DW    = 24,
    parameter int unsigned CFGAW = 32,
    parameter int unsigned CFGDW = 32,
    parameter int unsigned RW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    accum_decimator_if.slave   bus
);
    localparam int unsigned AW = DW + RW;
    localparam int unsigned SW = $clog2(RW + 1);

    logic [1:0][CFGDW-1:0] ctl;
    logic [15:0]           satcnt_q, satcnt_d;

    WbRegs #(
        .CFGAW       (CFGAW),
        .CFGDW       (CFGDW),
        .N_CTL       (2),
        .N_STS       (1),
        .STS_W       (16),
        .SIGN_EXTEND (1'b0),
        .CTL_RST     ({CFGDW'(0), CFGDW'(1)})
    ) u_regs (
        .clk     (clk),
        .rst     (!rst),
        .cyc_i   (bus.cyc_i),
        .stb_i   (bus.stb_i),
        .we_i    (bus.we_i),
        .addr_i  (bus.addr_i),
        .data_i  (bus.data_i),
        .ack_o   (bus.ack_o),
        .stall_o (bus.stall_o),
        .data_o  (bus.data_o),
        .ctl_o   (ctl),
        .sts_i   (satcnt_q)
    );

    logic [RW-1:0]        ratio_cfg, ratio_sh_q, ratio_sh_d, cur_ratio;
    logic [SW-1:0]        shift_cfg, shift_sh_q, shift_sh_d, cur_shift;
    logic [RW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d, sum;
    logic signed [DW-1:0] out_q, out_d;
    logic                 vld_q, vld_d;
    logic                 s_ready, accept, clipped;
    logic                 ratio_hi_unused;

    // RATIO is only RW bits wide; the upper bus bits are ignored on use.
    assign ratio_hi_unused = |ctl[ADDR_RATIO][CFGDW-1:RW];
    assign ratio_cfg = (ctl[ADDR_RATIO][RW-1:0] == '0) ? RW'(1) : ctl[ADDR_RATIO][RW-1:0];
    assign shift_cfg = (ctl[ADDR_SHIFT] > CFGDW'(RW)) ? SW'(RW) : ctl[ADDR_SHIFT][SW-1:0];

    always_comb begin
        s_ready    = rst && (!vld_q || bus.m_axis_tready);
        accept     = bus.s_axis_tvalid && s_ready;
        // The first sample of a block already uses the live config it is about to latch.
        cur_ratio  = (cnt_q == '0) ? ratio_cfg : ratio_sh_q;
        cur_shift  = (cnt_q == '0) ? shift_cfg : shift_sh_q;
        sum        = acc_q + AW'(bus.s_axis_tdata);
        clipped    = 1'b0;
        ratio_sh_d = ratio_sh_q;
        shift_sh_d = shift_sh_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_d      = out_q;
        vld_d      = vld_q;
        satcnt_d   = satcnt_q;
        if (vld_q && bus.m_axis_tready) vld_d = 1'b0;
        if (accept) begin
            if (cnt_q == '0) begin
                ratio_sh_d = ratio_cfg;
                shift_sh_d = shift_cfg;
            end
            if (cnt_q == cur_ratio - RW'(1)) begin
                out_d = DW'(round_shift_sat(64'(sum), 32'(cur_shift), DW, clipped));
                vld_d = 1'b1;
                acc_d = '0;
                cnt_d = '0;
                if (clipped && satcnt_q != '1) satcnt_d = satcnt_q + 16'd1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ratio_sh_q <= RW'(1);
            shift_sh_q <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            vld_q      <= 1'b0;
            satcnt_q   <= '0;
        end else begin
            ratio_sh_q <= ratio_sh_d;
            shift_sh_q <= shift_sh_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            vld_q      <= vld_d;
            satcnt_q   <= satcnt_d;
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tdata  = out_q;
    assign bus.m_axis_tvalid = vld_q;
endmodule

// File: tb/tb_accum_decimator.sv
// Scoreboard bench for accum_decimator: directed ratio/shift/saturation cases plus a randomly backpressured run.
module tb_accum_decimator;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    accum_decimator_if #(.DW(DW), .CFGAW(32), .CFGDW(32)) bus ();

    accum_decimator #(.DW(DW), .CFGAW(32), .CFGDW(32), .RW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint sb[$];
    int     out_cyc[$];
    int     cyc = 0;
    bit     rand_ready = 1'b0;
    bit     use_model = 1'b0;

    longint m_ratio = 1, m_shift = 0, sh_r = 1, sh_s = 0, m_cnt = 0, m_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, longint got, longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(longint x);
        longint s, r;
        if (m_cnt == 0) begin
            sh_r = m_ratio;
            sh_s = m_shift;
        end
        s = m_acc + x;
        if (m_cnt == sh_r - 1) begin
            r = s + ((sh_s > 0) ? (longint'(1) << (sh_s - 1)) : 0);
            r = r >>> sh_s;
            if (r > 8388607) r = 8388607;
            else if (r < -8388608) r = -8388608;
            sb.push_back(r);
            m_acc = 0;
            m_cnt = 0;
        end else begin
            m_acc = s;
            m_cnt++;
        end
    endtask

    // Output side: checks holds under backpressure, pops the scoreboard on each handshake.
    initial begin
        longint               exp;
        logic signed [DW-1:0] prev = '0;
        bit                   hold = 1'b0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (hold) begin
                    check("hold_valid", bus.m_axis_tvalid, 1);
                    check("hold_data", bus.m_axis_tdata, prev);
                end
                hold = bus.m_axis_tvalid && !bus.m_axis_tready;
                if (hold) begin
                    prev = bus.m_axis_tdata;
                    check("bp_sready", bus.s_axis_tready, 0);
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    exp = (sb.size() > 0) ? sb.pop_front() : 64'sh7fff_ffff;
                    check("out", bus.m_axis_tdata, exp);
                    out_cyc.push_back(cyc);
                end
            end else begin
                hold = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.m_axis_tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic send(longint x);
        int n = 0;
        bus.s_axis_tdata  = DW'(x);
        bus.s_axis_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_axis_tready && n < 500);
        if (!bus.s_axis_tready) check("send_timeout", bus.s_axis_tready, 1);
        else if (use_model) model_accept(x);
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic wb_xfer(bit we, int addr, longint wdata, output longint rdata);
        bus.cyc_i  = 1'b1;
        bus.stb_i  = 1'b1;
        bus.we_i   = we;
        bus.addr_i = 32'(addr);
        bus.data_i = 32'(wdata);
        @(posedge clk);
        #1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        @(negedge clk);
        check("ack", bus.ack_o, 1);
        rdata = longint'(bus.data_o);
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(int addr, longint data);
        longint dummy;
        wb_xfer(1'b1, addr, data, dummy);
        if (addr == 0) m_ratio = ((data & 255) == 0) ? 1 : (data & 255);
        if (addr == 1) m_shift = (data > 8) ? 8 : data;
    endtask

    task automatic wb_read(string tag, int addr, longint exp);
        longint rd;
        wb_xfer(1'b0, addr, 0, rd);
        check(tag, rd, exp);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int cfg_r[4] = '{3, 1, 7, 5};
        int cfg_s[4] = '{1, 0, 3, 2};
        logic signed [DW-1:0] v;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.addr_i = '0;  bus.data_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sready", bus.s_axis_tready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mvalid", bus.m_axis_tvalid, 0);
        check("rst_mdata", bus.m_axis_tdata, 0);
        check("rst_ack", bus.ack_o, 0);
        check("rst_stall", bus.stall_o, 0);
        check("rst_datao", bus.data_o, 0);
        @(posedge clk); #1;
        wb_read("rst_ratio", 0, 1);
        wb_read("rst_shift", 1, 0);

        // Passthrough at full rate.
        wb_write(0, 1); wb_write(1, 0);
        sb.push_back(5); sb.push_back(-7); sb.push_back(8388607);
        out_cyc.delete();
        send(5); send(-7); send(8388607);
        drain();
        check("pt_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) check("pt_rate", out_cyc[2] - out_cyc[0], 2);
        wb_read("pt_satcnt", 2, 0);

        wb_write(0, 4); wb_write(1, 2);
        sb.push_back(250);
        send(100); send(200); send(300); send(400);
        drain();

        wb_write(0, 2); wb_write(1, 1);
        sb.push_back(2); sb.push_back(-1);
        send(1); send(2); send(-1); send(-2);
        drain();

        wb_write(0, 4); wb_write(1, 0);
        sb.push_back(8388607);
        repeat (4) send(8388607);
        drain();
        wb_read("sat_cnt1", 2, 1);
        sb.push_back(-8388608);
        repeat (4) send(-8388608);
        drain();
        wb_read("sat_cnt2", 2, 2);
        wb_write(2, 0);
        wb_read("satcnt_ro", 2, 2);
        wb_read("unmapped", 7, 0);
        wb_read("ratio_rb", 0, 4);

        // RATIO 0 acts as 1; SHIFT above RW acts as RW.
        wb_write(0, 0); wb_write(1, 12);
        sb.push_back(1); sb.push_back(9);
        send(256);
        wb_write(1, 0);
        send(9);
        drain();

        // Mid-block ratio change applies from the next block.
        wb_write(0, 4); wb_write(1, 0);
        sb.push_back(10); sb.push_back(11); sb.push_back(15);
        send(1); send(2);
        wb_write(0, 2);
        send(3); send(4); send(5); send(6); send(7); send(8);
        drain();

        // Randomly backpressured run against the reference model.
        m_cnt = 0; m_acc = 0;
        use_model  = 1'b1;
        rand_ready = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            wb_write(0, cfg_r[seg]);
            wb_write(1, cfg_s[seg]);
            for (int k = 0; k < 250; k++) begin
                v = DW'($urandom);
                if ($urandom_range(0, 9) == 0) v = ($urandom_range(0, 1) == 1) ? 24'sh7fffff : 24'sh800000;
                send(longint'(v));
            end
        end
        drain();
        rand_ready = 1'b0;
        use_model  = 1'b0;

        // Reset mid-block drops the partial sum and restores RATIO=1.
        wb_write(0, 4); wb_write(1, 0);
        send(3); send(4);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst2_mvalid", bus.m_axis_tvalid, 0);
        @(posedge clk); #1;
        wb_read("rst2_ratio", 0, 1);
        repeat (4) sb.push_back(10);
        repeat (4) send(10);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
